// File: rtl/control_unit.sv
// control_unit: fetch/decode/sequence stage feeding the register-bank memory.
// One instruction per handshake; read, exec, optional write and retire phases.
module control_unit #(
  parameter int EXEC_CYCLES = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [17:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [2:0]       opcode,
  output logic [3:0]       addr1,
  output logic [3:0]       addr2,
  output logic [3:0]       dest,
  output logic             sinalImm,
  output logic [5:0]       Imm,
  output logic             we,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);
  localparam logic [2:0] IDLE = 3'd0, DECODE = 3'd1, EXEC = 3'd2, WRITE = 3'd3, DONE = 3'd4;
  localparam int EC = (EXEC_CYCLES < 1) ? 1 : ((EXEC_CYCLES > 15) ? 15 : EXEC_CYCLES);
  localparam logic [3:0] EC_LOAD = 4'(EC - 1);
  logic [2:0] state;
  logic [3:0] cnt;
  logic       itype;
  logic       unused_bits;
  // LOAD/ADDI/SUBI carry an immediate; CLEAR (110) decodes as R-type
  assign itype = ~instr[15] & (instr[17:16] != 2'b11);
  assign unused_bits = ^instr[2:0];
  assign instr_ready = state == IDLE;
  assign busy = state != IDLE;
  assign we = state == WRITE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      opcode <= '0;
      addr1 <= '0;
      addr2 <= '0;
      dest <= '0;
      sinalImm <= 1'b0;
      Imm <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE: if (instr_valid) begin
          opcode <= instr[17:15];
          dest <= instr[14:11];
          addr1 <= instr[10:7];
          addr2 <= itype ? 4'd0 : instr[6:3];
          sinalImm <= itype & instr[6];
          Imm <= itype ? instr[5:0] : 6'd0;
          state <= DECODE;
        end
        DECODE: begin
          cnt <= EC_LOAD;
          state <= EXEC;
        end
        EXEC: if (cnt == 4'd0) state <= (opcode == 3'b111) ? DONE : WRITE;
              else cnt <= cnt - 4'd1;
        WRITE: state <= DONE;
        DONE: begin
          instr_count <= instr_count + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed scoreboard bench for control_unit (default and CNT_W=2/EXEC_CYCLES=0).
module tb_control_unit;
  typedef struct {
    logic [2:0] op;
    logic [3:0] a1, a2, d;
    logic       s;
    logic [5:0] imm;
    int         cnt, wn, we_e, de;
  } exp_t;

  logic        clk = 0, rst_n = 0, sel = 0;
  logic [17:0] instr = '0;
  logic        v1 = 0, v2 = 0;
  logic        r1, r2, we1, we2, b1, b2, d1, d2, s1, s2;
  logic [2:0]  op1, op2;
  logic [3:0]  a11, a12, a21, a22, de1, de2;
  logic [5:0]  im1, im2;
  logic [7:0]  c1;
  logic [1:0]  c2;
  logic        m_ready, m_we, m_busy, m_done, m_s;
  logic [2:0]  m_op;
  logic [3:0]  m_a1, m_a2, m_d;
  logic [5:0]  m_imm;
  logic [7:0]  m_cnt;
  exp_t        sb[$];
  int          compared = 0, mismatched = 0, cnt1 = 0, cnt2 = 0;

  always #5 clk = ~clk;

  control_unit u1 (.clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(v1), .instr_ready(r1),
    .opcode(op1), .addr1(a11), .addr2(a21), .dest(de1), .sinalImm(s1), .Imm(im1), .we(we1),
    .busy(b1), .done(d1), .instr_count(c1));
  control_unit #(.EXEC_CYCLES(0), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .instr(instr),
    .instr_valid(v2), .instr_ready(r2), .opcode(op2), .addr1(a12), .addr2(a22), .dest(de2),
    .sinalImm(s2), .Imm(im2), .we(we2), .busy(b2), .done(d2), .instr_count(c2));

  assign m_ready = sel ? r2 : r1;
  assign m_we = sel ? we2 : we1;
  assign m_busy = sel ? b2 : b1;
  assign m_done = sel ? d2 : d1;
  assign m_s = sel ? s2 : s1;
  assign m_op = sel ? op2 : op1;
  assign m_a1 = sel ? a12 : a11;
  assign m_a2 = sel ? a22 : a21;
  assign m_d = sel ? de2 : de1;
  assign m_imm = sel ? im2 : im1;
  assign m_cnt = sel ? {6'd0, c2} : c1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [17:0] w, input bit fast);
    exp_t e;
    bit it, disp;
    int ec;
    it = (w[17:15] == 3'b000) || (w[17:15] == 3'b010) || (w[17:15] == 3'b100);
    disp = w[17:15] == 3'b111;
    ec = fast ? 1 : 2;
    e.op = w[17:15];
    e.d = w[14:11];
    e.a1 = w[10:7];
    e.a2 = it ? 4'd0 : w[6:3];
    e.s = it ? w[6] : 1'b0;
    e.imm = it ? w[5:0] : 6'd0;
    e.wn = disp ? 0 : 1;
    e.we_e = disp ? -1 : ec + 1;
    e.de = disp ? ec + 1 : ec + 2;
    return e;
  endfunction

  function automatic bit fields_ok(input exp_t e);
    return m_op === e.op && m_a1 === e.a1 && m_a2 === e.a2 && m_d === e.d && m_s === e.s && m_imm === e.imm;
  endfunction

  task automatic run(input logic [17:0] w);
    exp_t e, g;
    int k, wn, we_e;
    bit unstable;
    e = model(w, sel);
    if (sel) begin cnt2 = (cnt2 + 1) % 4; e.cnt = cnt2; end
    else begin cnt1 = (cnt1 + 1) % 256; e.cnt = cnt1; end
    sb.push_back(e);
    @(negedge clk);
    instr = w;
    if (sel) v2 = 1; else v1 = 1;
    @(posedge clk); #1;
    v1 = 0; v2 = 0;
    chk("accept_busy", m_busy, 1);
    k = 0; wn = 0; we_e = -1; unstable = 0;
    while (!m_done && k < 30) begin
      if (m_we) begin wn++; we_e = k; end
      if (!fields_ok(e)) unstable = 1;
      @(posedge clk); #1;
      k++;
    end
    chk("done_seen", m_done, 1);
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      g = sb.pop_front();
      chk("opcode", m_op, g.op);
      chk("addr1", m_a1, g.a1);
      chk("addr2", m_a2, g.a2);
      chk("dest", m_d, g.d);
      chk("sinalImm", m_s, g.s);
      chk("Imm", m_imm, g.imm);
      chk("stable", unstable, 0);
      chk("we_pulses", wn, g.wn);
      chk("we_edge", we_e, g.we_e);
      chk("done_edge", k, g.de);
      @(posedge clk); #1;
      chk("done_1cyc", m_done, 0);
      chk("count", m_cnt, g.cnt);
      chk("ready_back", m_ready, 1);
      chk("idle_hold", fields_ok(g), 1);
    end
  endtask

  initial begin
    exp_t ea, eb;
    int k;
    bit unstable;
    #3;
    chk("rst_ready", r1, 1);
    chk("rst_busy", b1, 0);
    chk("rst_we", we1, 0);
    chk("rst_done", d1, 0);
    chk("rst_count", c1, 0);
    chk("rst_fields", {op1, a11, a21, de1, s1, im1}, 0);
    @(negedge clk); rst_n = 1;
    run({3'b001, 4'd3, 4'd1, 4'd2, 3'b000});
    run({3'b010, 4'd5, 4'd4, 1'b1, 6'd42});
    run({3'b111, 4'd1, 4'd2, 4'd3, 3'b101});
    run({3'b100, 4'd15, 4'd9, 1'b0, 6'd63});
    run({3'b101, 4'd7, 4'd8, 4'd14, 3'b111});
    run({3'b110, 4'd2, 4'd11, 4'd6, 3'b010});
    run({3'b000, 4'd10, 4'd12, 1'b1, 6'd1});
    // held valid: B must not be taken until the first IDLE edge after A retires
    ea = model({3'b011, 4'd6, 4'd5, 4'd4, 3'b000}, 0);
    eb = model({3'b010, 4'd9, 4'd3, 1'b0, 6'd17}, 0);
    @(negedge clk);
    instr = {3'b011, 4'd6, 4'd5, 4'd4, 3'b000}; v1 = 1;
    @(posedge clk); #1;
    instr = {3'b010, 4'd9, 4'd3, 1'b0, 6'd17};
    k = 0; unstable = 0;
    while (!d1 && k < 30) begin
      if (!fields_ok(ea)) unstable = 1;
      @(posedge clk); #1;
      k++;
    end
    chk("hold_done_edge", k, 4);
    chk("hold_stable", unstable, 0);
    @(posedge clk); #1;
    cnt1++;
    chk("hold_idle_ready", r1, 1);
    chk("hold_not_taken", fields_ok(ea), 1);
    @(posedge clk); #1;
    v1 = 0;
    chk("hold_taken_busy", b1, 1);
    chk("hold_taken_fields", fields_ok(eb), 1);
    k = 0;
    while (b1 && k < 30) begin @(posedge clk); #1; k++; end
    cnt1++;
    chk("hold_count", c1, cnt1);
    // async reset in the middle of WRITE
    @(negedge clk);
    instr = {3'b001, 4'd1, 4'd1, 4'd1, 3'b000}; v1 = 1;
    @(posedge clk); #1;
    v1 = 0;
    k = 0;
    while (!we1 && k < 30) begin @(negedge clk); k++; end
    chk("reach_write", we1, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_we", we1, 0);
    chk("arst_busy", b1, 0);
    chk("arst_ready", r1, 1);
    chk("arst_count", c1, 0);
    chk("arst_opcode", op1, 0);
    cnt1 = 0; cnt2 = 0;
    @(negedge clk); rst_n = 1;
    sel = 1;
    run({3'b001, 4'd3, 4'd1, 4'd2, 3'b000});
    run({3'b111, 4'd0, 4'd5, 4'd0, 3'b000});
    run({3'b010, 4'd5, 4'd4, 1'b1, 6'd42});
    run({3'b101, 4'd8, 4'd2, 4'd3, 3'b000});
    run({3'b100, 4'd1, 4'd7, 1'b0, 6'd5});
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Fetch/decode/sequence stage directly upstream of the register-bank memory block.
- Accepts one 18-bit instruction word per transaction through a valid/ready handshake and splits it into the memory's control fields: opcode, addr1, addr2, dest, sinalImm, Imm.
- Sequences the memory/ALU through read, execute and write phases, pulsing we exactly once per writing instruction.
- Signals completion and counts retired instructions.

Parameters:
- EXEC_CYCLES, 2, cycles spent in EXEC waiting for the ALU result to settle. Range 1..15; a value of 0 is treated as 1.
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr  input  18  instruction word, sampled only on accept.
- instr_valid  input  1  upstream has an instruction on instr.
- instr_ready  output  1  block can accept an instruction (high only in IDLE).
- opcode  output  3  to memory opcode.
- addr1  output  4  to memory addr1 (source 1).
- addr2  output  4  to memory addr2 (source 2).
- dest  output  4  to memory dest.
- sinalImm  output  1  to memory sinalImm (immediate sign).
- Imm  output  6  to memory Imm (immediate magnitude).
- we  output  1  to memory we.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when an instruction retires.
- instr_count  output  CNT_W  retired-instruction counter.

Behaviour:
- Instruction format:
  - instr[17:15] opcode.
  - instr[14:11] dest.
  - instr[10:7] src1.
  - R-type: instr[6:3] src2; instr[2:0] ignored.
  - I-type: instr[6] sign, instr[5:0] magnitude.
- Opcode map:
  - I-type: 000 LOAD, 010 ADDI, 100 SUBI.
  - R-type: 001 ADD, 011 SUB, 101 MUL.
  - 110 CLEAR writes (R-type decode).
  - 111 DISPLAY is read-only; no write phase.
- Field decode:
  - R-type: sinalImm=0, Imm=0, addr2=instr[6:3].
  - I-type: addr2=0, sinalImm=instr[6], Imm=instr[5:0].
  - All types: addr1=instr[10:7], dest=instr[14:11].
- States: IDLE, DECODE, EXEC, WRITE, DONE.
- Transitions:
  - IDLE: instr_valid && instr_ready at a rising edge captures instr into the internal register -> DECODE.
  - DECODE: one cycle; fields driven from the captured word, we=0, so the memory presents q1/q2 -> EXEC.
  - EXEC: exec counter loads at EXEC_CYCLES-1 and decrements. At 0 -> WRITE, or -> DONE if opcode==111.
  - WRITE: exactly one cycle, we=1 -> DONE.
  - DONE: one cycle, done=1; instr_count increments (wraps 2^CNT_W-1 -> 0) -> IDLE.
- Outputs:
  - All field outputs are registered and update only on the accept edge.
  - Field outputs stay stable from DECODE through DONE and hold their last value in IDLE.
  - we=1 only in WRITE.
- Latency, with accept at edge E0 and EXEC_CYCLES=2:
  - DECODE E0-E1, EXEC E1-E3.
  - we high E3-E4; done high E4-E5; instr_ready high again after E5.
  - Accept-to-done: 4 edges (writing) or 3 edges (DISPLAY).
  - Back-to-back throughput: one instruction per 5 cycles.
- Handshake rules:
  - instr_valid while not ready is ignored; instr changes while busy have no effect.
  - Upstream must hold instr stable while valid && !ready.
- Reset:
  - rst_n low forces, immediately and asynchronously: state=IDLE, all field outputs=0, we=0, done=0, busy=0, instr_count=0, exec counter=0, captured instr=0.
  - instr_ready=1 in reset and after release.
  - Reset mid-WRITE drops we the same instant; no partial retire, and the count is not incremented.
- Valid sampled in the same cycle rst_n rises is accepted only on the first rising edge with rst_n high.

Test Plan:
- Reset, then instr={001,0011,0001,0010,000} with valid=1 -> accept, addr1=1, addr2=2, dest=3, sinalImm=0, Imm=0; we high exactly one cycle, 3 edges after accept; done 1 cycle later; instr_count=1.
- ADDI with instr={010,0101,0100,1,101010} -> sinalImm=1, Imm=42, addr1=4, addr2=0, dest=5; single we pulse; fields stable from DECODE to DONE.
- DISPLAY {111,...} -> we never asserted; done 3 edges after accept; instr_count increments.
- Hold valid=1 with a new instr during busy -> not captured, outputs unchanged; captured only on the next IDLE edge, giving 5-cycle spacing.
- Assert rst_n=0 while in WRITE -> we falls asynchronously with no clock, busy=0, instr_count=0, instr_ready=1.
- Set CNT_W=2 and retire 5 instructions -> instr_count reads 1,2,3,0,1; with EXEC_CYCLES=0, timing is identical to EXEC_CYCLES=1.
